// File: rtl/bubble_power_sequencer.sv
// ---------------------------------------------------------------------------
// bubble_power_sequencer
//
// Host-side power sequencer for the bubble memory cartridge. Holds
// power_good low for a settle period after a start request, then raises it
// and waits for the cartridge READY line (temperature_low). READY is
// synchronized and debounced before use. Once READY is stable the host is
// told it may proceed (host_ready). A missing READY (timeout) or a READY
// dropout while running raises a sticky fault.
//
// Optional feature: define AUTO_RETRY_EN to let the sequencer re-cycle power
// automatically (up to MAX_RETRIES times, with a BACKOFF pause) after a
// fault. Without the macro a fault is terminal until start is dropped.
//
// Ports
//   master_clock     in   1  system clock
//   reset            in   1  synchronous, active-high reset
//   start            in   1  level request to power up and run the cartridge
//   temperature_low  in   1  cartridge READY, asynchronous
//   power_good       out  1  power-good to the cartridge
//   host_ready       out  1  cartridge up and READY stable
//   fault            out  1  sticky fault flag (cleared only in IDLE)
//   fault_code       out  2  00 none, 01 READY timeout, 10 READY dropout
//   retry_count      out  4  automatic retries used since the last IDLE
//   state_out        out  3  FSM state, for debug
// ---------------------------------------------------------------------------
module bubble_power_sequencer #(
  parameter int SETTLE_CYCLES  = 64,
  parameter int READY_TIMEOUT  = 1024,
  parameter int READY_FILTER   = 4,
  parameter int MAX_RETRIES    = 2,
  parameter int BACKOFF_CYCLES = 128
) (
  input  logic       master_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       temperature_low,
  output logic       power_good,
  output logic       host_ready,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] retry_count,
  output logic [2:0] state_out
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX  = max2(max2(SETTLE_CYCLES, READY_TIMEOUT), BACKOFF_CYCLES);
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;
  localparam int FILT_W   = $clog2(READY_FILTER) + 1;

  localparam logic [CNT_W-1:0]  L_SETTLE_END  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  L_TIMEOUT_END = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  L_BACKOFF_END = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  L_CNT_ONE     = CNT_W'(1);
  localparam logic [FILT_W-1:0] L_FILT_END    = FILT_W'(READY_FILTER - 1);
  localparam logic [FILT_W-1:0] L_FILT_ONE    = FILT_W'(1);
  localparam logic [3:0]        L_MAX_RETRIES = 4'(MAX_RETRIES);

`ifdef AUTO_RETRY_EN
  localparam bit L_AUTO_RETRY = 1'b1;
`else
  // FAULT is terminal; BACKOFF can never be entered.
  localparam bit L_AUTO_RETRY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETTLE     = 3'd1,
    S_WAIT_READY = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4,
    S_BACKOFF    = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_sync;
  logic                r_filt;
  logic [FILT_W-1:0]   r_fcnt;
  logic                w_rdy_sync;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + L_CNT_ONE);
  endfunction

  function automatic logic [3:0] retry_inc(input logic [3:0] v);
    return (&v) ? v : (v + 4'd1);
  endfunction

  assign w_rdy_sync = r_sync[2];
  assign state_out  = r_state;

  // Next-state logic. Dropping start overrides every other transition.
  always_comb begin
    w_next = r_state;
    if (!start) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       w_next = S_SETTLE;
        S_SETTLE:     if (r_cnt == L_SETTLE_END) w_next = S_WAIT_READY;
        // A READY arriving on the timeout cycle still wins.
        S_WAIT_READY: begin
          if (r_filt)                      w_next = S_RUN;
          else if (r_cnt == L_TIMEOUT_END) w_next = S_FAULT;
        end
        S_RUN:        if (!r_filt) w_next = S_FAULT;
        S_FAULT:      if (L_AUTO_RETRY && (retry_count < L_MAX_RETRIES)) w_next = S_BACKOFF;
        S_BACKOFF:    if (r_cnt == L_BACKOFF_END) w_next = S_SETTLE;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  // State, counters, READY conditioning and registered outputs.
  // Outputs are decoded from the next state so they change on the same edge
  // as the state itself (e.g. power_good drops with the abort edge).
  always_ff @(posedge master_clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sync      <= '0;
      r_filt      <= 1'b0;
      r_fcnt      <= '0;
      power_good  <= 1'b0;
      host_ready  <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      retry_count <= 4'd0;
    end else begin
      r_sync <= {r_sync[1:0], temperature_low};

      // Symmetric debounce: READY_FILTER consecutive opposite samples flip
      // the filtered value; any agreeing sample restarts the count.
      if (w_rdy_sync != r_filt) begin
        if (r_fcnt == L_FILT_END) begin
          r_filt <= ~r_filt;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + L_FILT_ONE;
        end
      end else begin
        r_fcnt <= '0;
      end

      r_state <= w_next;
      // One shared timer, restarted on every state change.
      r_cnt   <= (w_next != r_state) ? '0 : cnt_inc(r_cnt);

      power_good <= (w_next == S_WAIT_READY) || (w_next == S_RUN);
      host_ready <= (w_next == S_RUN);

      if (w_next == S_IDLE) begin
        fault       <= 1'b0;
        fault_code  <= 2'b00;
        retry_count <= 4'd0;
      end else begin
        // fault and fault_code stay latched through BACKOFF and retries.
        if ((w_next == S_FAULT) && (r_state != S_FAULT)) begin
          fault      <= 1'b1;
          fault_code <= (r_state == S_RUN) ? 2'b10 : 2'b01;
        end
        if ((r_state == S_BACKOFF) && (w_next == S_SETTLE)) begin
          retry_count <= retry_inc(retry_count);
        end
      end
    end
  end

endmodule
